uart_mmio: RTL

- Memory-mapped 8N1 UART peripheral on the PicoRV32 native memory bus, directly downstream of the core's bus in the picorv_uart top.
- Converts CPU loads and stores in its address window into serial TX/RX traffic on tx_o/rx_i.
- The DV runner's memory model serves all addresses outside the window.
- Contains: bus slave, TX holding register plus shifter, RX synchroniser/sampler plus 1-entry RX buffer, programmable baud divider.

---
 rtl/uart_mmio.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART slave for the PicoRV32 native bus.
// Register window is 16 bytes at BaseAddr: DATA, STATUS, DIV, CLR.
// Bus handshake: a request is taken in the first cycle mem_valid_i is high,
// the window matches, no ack is already in flight and the request is not a
// DATA write blocked by a full TX holding register. mem_ready_o pulses high
// for exactly one cycle in the following cycle, with mem_rdata_o valid.
module uart_mmio #(
    parameter logic [31:0] BaseAddr   = 32'h1000_0000,
    parameter logic [15:0] DefaultDiv = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic        sel_o,
    output logic        tx_o,
    input  logic        rx_i,
    output logic        irq_o
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    logic        mem_ready_q, take, is_wr, stall;
    logic        wr_data, rd_data, wr_div, wr_clr;
    logic [1:0]  reg_off;
    logic [31:0] mem_rdata_q, rd_mux;
    logic [15:0] div_q, div_d, div_wr_val;
    logic [4:0]  status;

    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;
    logic        tx_full_q, tx_full_d, load_shift;

    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
    logic        byte_good;

    // Bits of the bus the register map never looks at.
    logic unused_bits;
    assign unused_bits = &{1'b0, mem_wdata_i[31:16], mem_wstrb_i[3:2], mem_addr_i[1:0]};

    assign sel_o   = mem_valid_i && (mem_addr_i[31:4] == BaseAddr[31:4]);
    assign reg_off = mem_addr_i[3:2];
    assign is_wr   = |mem_wstrb_i;
    assign stall   = is_wr && (reg_off == 2'd0) && mem_wstrb_i[0] && tx_full_q;
    assign take    = sel_o && !mem_ready_q && !stall;
    assign wr_data = take && is_wr && (reg_off == 2'd0) && mem_wstrb_i[0];
    assign rd_data = take && !is_wr && (reg_off == 2'd0);
    assign wr_div  = take && is_wr && (reg_off == 2'd2);
    assign wr_clr  = take && is_wr && (reg_off == 2'd3) && mem_wstrb_i[0];

    assign status      = {rx_ferr_q, rx_ovr_q, rx_valid_q, tx_full_q, tx_state_q != S_IDLE};
    assign mem_ready_o = mem_ready_q;
    assign mem_rdata_o = mem_rdata_q;
    assign irq_o       = rx_valid_q;
    assign tx_o        = (tx_state_q == S_START) ? 1'b0 :
                         (tx_state_q == S_DATA)  ? tx_shift_q[0] : 1'b1;

    // Read mux and byte-gated DIV update with the minimum of 4 enforced.
    always_comb begin
        rd_mux = '0;
        case (reg_off)
            2'd0:    rd_mux = {24'b0, rx_byte_q};
            2'd1:    rd_mux = {27'b0, status};
            2'd2:    rd_mux = {16'b0, div_q};
            default: rd_mux = '0;
        endcase
        div_wr_val = {mem_wstrb_i[1] ? mem_wdata_i[15:8] : div_q[15:8],
                      mem_wstrb_i[0] ? mem_wdata_i[7:0]  : div_q[7:0]};
        div_d = div_q;
        if (wr_div) div_d = (div_wr_val < 16'd4) ? 16'd4 : div_wr_val;
    end

    // Bus ack pulse, read data capture and the divider register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            div_q       <= DefaultDiv;
        end else begin
            mem_ready_q <= take;
            mem_rdata_q <= (take && !is_wr) ? rd_mux : '0;
            div_q       <= div_d;
        end
    end

    // TX next state: bit timing, holding-register handoff, back-to-back frames.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        tx_full_d  = tx_full_q;
        load_shift = 1'b0;
        case (tx_state_q)
            S_IDLE:  load_shift = tx_full_q;
            S_START: begin
                if (tx_cnt_q == 16'd1) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = div_q;
                    tx_bit_d   = 3'd0;
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
            S_DATA: begin
                if (tx_cnt_q == 16'd1) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_cnt_d   = div_q;
                    if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                    else tx_bit_d = tx_bit_q + 3'd1;
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
            default: begin
                if (tx_cnt_q == 16'd1) begin
                    if (tx_full_q) load_shift = 1'b1;
                    else tx_state_d = S_IDLE;
                end else tx_cnt_d = tx_cnt_q - 16'd1;
            end
        endcase
        if (load_shift) begin
            tx_state_d = S_START;
            tx_cnt_d   = div_q;
            tx_shift_d = tx_hold_q;
            tx_full_d  = 1'b0;
        end
        // wr_data is only taken while the holding register is empty.
        if (wr_data) begin
            tx_hold_d = mem_wdata_i[7:0];
            tx_full_d = 1'b1;
        end
    end

    // TX state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_hold_q  <= '0;
            tx_full_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_hold_q  <= tx_hold_d;
            tx_full_q  <= tx_full_d;
        end
    end

    // RX next state: start validation, mid-bit sampling, buffer and flags.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        rx_ferr_d  = rx_ferr_q;
        byte_good  = 1'b0;
        if (wr_clr && mem_wdata_i[3]) rx_ovr_d  = 1'b0;
        if (wr_clr && mem_wdata_i[4]) rx_ferr_d = 1'b0;
        if (rd_data) rx_valid_d = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = {1'b0, div_q[15:1]};
                end
            end
            S_START: begin
                if (rx_cnt_q == 16'd1) begin
                    rx_cnt_d = div_q;
                    rx_bit_d = 3'd0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            S_DATA: begin
                if (rx_cnt_q == 16'd1) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = div_q;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else rx_bit_d = rx_bit_q + 3'd1;
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
            default: begin
                if (rx_cnt_q == 16'd1) begin
                    rx_state_d = S_IDLE;
                    if (rx_s2_q) byte_good = 1'b1;
                    else rx_ferr_d = 1'b1;
                end else rx_cnt_d = rx_cnt_q - 16'd1;
            end
        endcase
        // A read in the completion cycle frees the buffer for the new byte.
        if (byte_good) begin
            if (!rx_valid_q || rd_data) begin
                rx_byte_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end else rx_ovr_d = 1'b1;
        end
    end

    // RX synchroniser, edge history and state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_s1_q    <= rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end
endmodule
